// File: rtl/mc_pi_estimator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_pi_estimator : Monte-Carlo pi estimator, N_CH parallel LFSR sample lanes |
// | Optional define MC_PI_SEED_IN_EN takes the base seed from the seed port.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mc_pi_estimator #(
  parameter int N_CH         = 4,
  parameter int LFSR_W       = 16,
  parameter int LOG2_SAMPLES = 20,
  parameter int FRAC_W       = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LFSR_W-1:0]       seed,
  output logic                    busy,
  output logic                    done,
  output logic [LOG2_SAMPLES:0]   hits_out,
  output logic [FRAC_W+2:0]       pi_out
);

  localparam int LOG2_N = $clog2(N_CH);
  localparam int ACC_W  = LOG2_SAMPLES + 1;
  localparam int CNT_W  = LOG2_SAMPLES + 1;
  localparam int POP_W  = $clog2(N_CH + 1);
  localparam int PW     = LOG2_SAMPLES + FRAC_W + 4;
  localparam int HALF   = LFSR_W / 2;
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'((1 << (LOG2_SAMPLES - LOG2_N)) - 1);
  localparam logic [2*LFSR_W:0] SUM_LIM = {1'b1, {(2*LFSR_W){1'b0}}};

  // Galois feedback masks of maximal-length polynomials, indexed by width
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0007_2000;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [LFSR_W-1:0] MASK = LFSR_W'(tap_mask(LFSR_W));

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ MASK) : (v >> 1);
  endfunction

  function automatic logic [LFSR_W-1:0] non_zero(input logic [LFSR_W-1:0] v);
    return (v == '0) ? LFSR_W'(1) : v;
  endfunction

  function automatic logic [2*LFSR_W-1:0] square(input logic [LFSR_W-1:0] v);
    return {{LFSR_W{1'b0}}, v} * {{LFSR_W{1'b0}}, v};
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t              state, state_nx;
  logic                accept;
  logic [CNT_W-1:0]    cnt;
  logic                valid1;
  logic [ACC_W-1:0]    acc;
  logic [N_CH-1:0]     hit;
  logic [POP_W-1:0]    pop;
  logic [LFSR_W-1:0]   base, base_rot;
  logic [PW-1:0]       pi_wide;
  logic                unused_pi_hi;

`ifdef MC_PI_SEED_IN_EN
  assign base = seed;
`else
  localparam logic [31:0] BASE_CONST = 32'h0000_ACE1;
  logic unused_seed;
  assign base        = BASE_CONST[LFSR_W-1:0];
  assign unused_seed = ^seed;
`endif

  assign base_rot = (base << HALF) | (base >> (LFSR_W - HALF));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE:    if (start) begin
                 accept   = 1'b1;
                 state_nx = RUN;
               end
      RUN:     if (cnt == S_LAST) state_nx = DRAIN;
      DRAIN:   if (cnt[0]) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_lane
      logic [LFSR_W-1:0]   x, y;
      logic [2*LFSR_W-1:0] sqx, sqy;
      logic [2*LFSR_W:0]   sum;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x   <= LFSR_W'(1);
          y   <= LFSR_W'(1);
          sqx <= '0;
          sqy <= '0;
        end else begin
          if (accept) begin
            x <= non_zero(base ^ LFSR_W'(2*k + 1));
            y <= non_zero(base_rot ^ LFSR_W'(2*k + 2));
          end else if (state == RUN) begin
            x <= lfsr_step(x);
            y <= lfsr_step(y);
          end
          sqx <= square(x);
          sqy <= square(y);
        end
      end

      assign sum    = {1'b0, sqx} + {1'b0, sqy};
      assign hit[k] = (sum < SUM_LIM);
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int k = 0; k < N_CH; k++) pop = pop + POP_W'(hit[k]);
  end

  // hits may reach 2^LOG2_SAMPLES exactly, which maps to 4.0
  assign pi_wide      = (PW'(acc) << (FRAC_W + 2)) >> LOG2_SAMPLES;
  assign unused_pi_hi = ^pi_wide[PW-1:FRAC_W+3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      valid1   <= 1'b0;
      acc      <= '0;
      hits_out <= '0;
      pi_out   <= '0;
    end else begin
      state  <= state_nx;
      valid1 <= (state == RUN);
      if (state_nx != state) cnt <= '0;
      else if (state == RUN || state == DRAIN) cnt <= cnt + CNT_W'(1);
      if (accept) acc <= '0;
      else if (valid1) acc <= acc + ACC_W'(pop);
      if (state == DRAIN && state_nx == DONE) begin
        hits_out <= acc;
        pi_out   <= pi_wide[FRAC_W+2:0];
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule
`default_nettype wire
